// File: rtl/conv_psum_accumulator_pkg.sv
// Shared widths, Q-format defaults and FSM state encodings for the
// partial-sum accumulator and its output stage.
package conv_psum_accumulator_pkg;

  localparam int DEF_DATA_BITS   = 16;
  localparam int DEF_FRAC_BITS   = 8;
  localparam int DEF_KERNEL_TAPS = 9;
  localparam int DEF_ACC_BITS    = 36;

  localparam logic [1:0] ST_ACC    = 2'd0;
  localparam logic [1:0] ST_FINISH = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/conv_psum_accumulator_sat_relu_16b.sv
// Combinational output stage: adds the bias, rounds half up, optionally
// clamps negatives to zero and saturates the sum to DATA_BITS.
module sat_relu_16b
  import conv_psum_accumulator_pkg::*;
#(
  parameter int ACC_BITS  = DEF_ACC_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [ACC_BITS-1:0]  acc,
  input  logic signed [DATA_BITS-1:0] bias,
  input  logic                        relu_en,
  output logic signed [DATA_BITS-1:0] result
);

  // Two guard bits keep the bias and rounding additions from ever wrapping.
  localparam int SUM_BITS = ACC_BITS + 2;
  localparam logic signed [SUM_BITS-1:0] ROUND_HALF = SUM_BITS'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [SUM_BITS-1:0] SAT_MAX    = SUM_BITS'((64'sd1 <<< (DATA_BITS - 1)) - 64'sd1);
  localparam logic signed [SUM_BITS-1:0] SAT_MIN    = SUM_BITS'(-(64'sd1 <<< (DATA_BITS - 1)));

  logic signed [SUM_BITS-1:0] acc_ext;
  logic signed [SUM_BITS-1:0] bias_ext;
  logic signed [SUM_BITS-1:0] sum;
  logic signed [SUM_BITS-1:0] rounded;
  logic signed [SUM_BITS-1:0] clamped;

  // Round, ReLU and saturate in one combinational pass.
  always_comb begin
    acc_ext  = SUM_BITS'(acc);
    bias_ext = SUM_BITS'(bias) <<< FRAC_BITS;
    sum      = acc_ext + bias_ext + ROUND_HALF;
    rounded  = sum >>> FRAC_BITS;
    if (relu_en && rounded[SUM_BITS-1]) begin
      clamped = {SUM_BITS{1'b0}};
    end else begin
      clamped = rounded;
    end
    if (clamped > SAT_MAX) begin
      result = DATA_BITS'(SAT_MAX);
    end else if (clamped < SAT_MIN) begin
      result = DATA_BITS'(SAT_MIN);
    end else begin
      result = DATA_BITS'(clamped);
    end
  end

endmodule

// File: rtl/conv_psum_accumulator.sv
// Per-output-pixel MAC stage: accumulates KERNEL_TAPS pixel*weight products,
// then emits the biased, rounded, optionally ReLU'd and saturated result.
module conv_psum_accumulator
  import conv_psum_accumulator_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int KERNEL_TAPS = DEF_KERNEL_TAPS,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int ACC_BITS    = DEF_ACC_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_BITS-1:0] pixel,
  input  logic signed [DATA_BITS-1:0] weight,
  input  logic signed [DATA_BITS-1:0] bias,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_BITS-1:0] out_data,
  output logic                        busy
);

  localparam int CNT_BITS  = $clog2(KERNEL_TAPS + 1);
  localparam int PROD_BITS = 2 * DATA_BITS;
  localparam logic [CNT_BITS-1:0] LAST_TAP = CNT_BITS'(KERNEL_TAPS - 1);

  logic [1:0]                  state;
  logic signed [ACC_BITS-1:0]  acc;
  logic [CNT_BITS-1:0]         tap_cnt;
  logic signed [DATA_BITS-1:0] bias_q;
  logic signed [PROD_BITS-1:0] product;
  logic signed [ACC_BITS-1:0]  product_ext;
  logic signed [DATA_BITS-1:0] result;
  logic                        tap_fire;

  // Ready is forced low while reset is asserted, not just after it.
  assign in_ready    = (state == ST_ACC) && !rst;
  assign tap_fire    = in_valid && in_ready;
  assign product     = pixel * weight;
  assign product_ext = {{(ACC_BITS - PROD_BITS){product[PROD_BITS-1]}}, product};

  sat_relu_16b #(
    .ACC_BITS  (ACC_BITS),
    .DATA_BITS (DATA_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_relu (
    .acc     (acc),
    .bias    (bias_q),
    .relu_en (relu_en),
    .result  (result)
  );

  // Window FSM, accumulator and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= {ACC_BITS{1'b0}};
      tap_cnt   <= {CNT_BITS{1'b0}};
      bias_q    <= {DATA_BITS{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {DATA_BITS{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (tap_fire) begin
            acc     <= acc + product_ext;
            tap_cnt <= tap_cnt + CNT_BITS'(1);
            busy    <= 1'b1;
            if (tap_cnt == {CNT_BITS{1'b0}}) begin
              bias_q <= bias;
            end
            if (tap_cnt == LAST_TAP) begin
              state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= {ACC_BITS{1'b0}};
            tap_cnt   <= {CNT_BITS{1'b0}};
            busy      <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Directed, table-driven bench for conv_psum_accumulator plus hand-written
// sequences for output back-pressure and mid-window reset.
module tb_conv_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pixel;
  logic [15:0] weight;
  logic [15:0] bias;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] pixel;
    logic [15:0] weight;
    logic [15:0] bias;
    logic        relu;
    logic        gap;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  conv_psum_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel     (pixel),
    .weight    (weight),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Feeds n taps; returns at the negedge after the last accepting edge.
  task automatic feed_taps(input vec_t v, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      if (v.gap && i > 0) begin
        in_valid = 1'b0;
        pixel    = 16'h7777;
        @(negedge clk);
      end
      in_valid = 1'b1;
      pixel    = v.pixel;
      weight   = v.weight;
      bias     = (i == 0) ? v.bias : 16'h5A5A;
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) check({v.name, "_ready_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      if (i == 0) check({v.name, "_busy_first"}, busy, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_window(input vec_t v);
    @(negedge clk);
    relu_en   = v.relu;
    out_ready = 1'b0;
    feed_taps(v, 9);
    check({v.name, "_finish_valid"}, out_valid, 32'd0);
    check({v.name, "_finish_ready"}, in_ready, 32'd0);
    @(negedge clk);
    check({v.name, "_valid"}, out_valid, 32'd1);
    check({v.name, "_data"}, out_data, v.exp);
    check({v.name, "_hold_ready"}, in_ready, 32'd0);
    check({v.name, "_hold_busy"}, busy, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.name, "_post_valid"}, out_valid, 32'd0);
    check({v.name, "_post_ready"}, in_ready, 32'd1);
    check({v.name, "_post_busy"}, busy, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"unity",       16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0900};
    vecs[1]  = '{"neg",         16'h0100, 16'hFF00, 16'h0000, 1'b0, 1'b0, 16'hF700};
    vecs[2]  = '{"neg_relu",    16'h0100, 16'hFF00, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{"pos_sat",     16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h7FFF};
    vecs[4]  = '{"neg_sat",     16'h7FFF, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h8000};
    vecs[5]  = '{"round_up",    16'h0001, 16'h0080, 16'h0000, 1'b0, 1'b1, 16'h0005};
    vecs[6]  = '{"round_bias",  16'h0001, 16'h0080, 16'h0100, 1'b0, 1'b1, 16'h0105};
    vecs[7]  = '{"neg_bias",    16'h0100, 16'h0000, 16'hFF80, 1'b0, 1'b0, 16'hFF80};
    vecs[8]  = '{"nbias_relu",  16'h0100, 16'h0000, 16'hFF80, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{"round_down",  16'h0001, 16'h0070, 16'h0000, 1'b0, 1'b0, 16'h0004};
    vecs[10] = '{"pos_relu",    16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0900};

    rst       = 1'b1;
    in_valid  = 1'b0;
    pixel     = 16'h0000;
    weight    = 16'h0000;
    bias      = 16'h0000;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_busy", busy, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 32'd1);

    for (int i = 0; i < 11; i++) run_window(vecs[i]);

    // Back-pressure: output must hold for 5 cycles with input blocked.
    @(negedge clk);
    relu_en = 1'b0;
    feed_taps(vecs[0], 9);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      pixel    = 16'h7FFF;
      check("hold_valid", out_valid, 32'd1);
      check("hold_data", out_data, 32'h0900);
      check("hold_ready", in_ready, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_ready", in_ready, 32'd1);
    check("release_valid", out_valid, 32'd0);
    run_window(vecs[1]);

    // Reset after 4 taps discards the partial window.
    @(negedge clk);
    feed_taps(vecs[3], 4);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_ready", in_ready, 32'd0);
    check("midrst_busy", busy, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_window(vecs[0]);

    // Reset while holding a result drops it without a spurious valid.
    @(negedge clk);
    feed_taps(vecs[1], 9);
    @(negedge clk);
    check("holdrst_pre_valid", out_valid, 32'd1);
    rst = 1'b1;
    #1;
    check("holdrst_valid", out_valid, 32'd0);
    check("holdrst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("holdrst_idle_valid", out_valid, 32'd0);
    run_window(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
